// File: rtl/pipeline_trace_buffer.sv
// rtl/pipeline_trace_buffer.sv - pipeline trace capture buffer with trigger, ring mode and drain port
module pipeline_trace_buffer #(
  parameter int ADDR_W   = 32,
  parameter int REG_W    = 32,
  parameter int NUM_REGS = 4,
  parameter int DEPTH    = 16,
  parameter int STAMP_W  = 16,
  parameter int PCNT_W   = 8
) (
  input  logic                                         clock,
  input  logic                                         reset_n,
  input  logic [ADDR_W-1:0]                            pc_in,
  input  logic                                         hold_in,
  input  logic                                         flush_in,
  input  logic [1:0]                                   fw1_in,
  input  logic [1:0]                                   fw2_in,
  input  logic [NUM_REGS*REG_W-1:0]                    regs_in,
  input  logic                                         arm,
  input  logic                                         stop,
  input  logic                                         mode,
  input  logic                                         trig_en,
  input  logic [ADDR_W-1:0]                            trig_pc,
  input  logic [PCNT_W-1:0]                            post_count,
  output logic                                         rd_valid,
  input  logic                                         rd_ready,
  output logic [STAMP_W+ADDR_W+6+NUM_REGS*REG_W-1:0]   rd_data,
  output logic [1:0]                                   state,
  output logic [$clog2(DEPTH):0]                       count,
  output logic                                         overflow,
  output logic                                         triggered
);

  localparam int E  = STAMP_W + ADDR_W + 6 + NUM_REGS * REG_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [STAMP_W-1:0]  stamp_q, stamp_d;
  logic                overflow_q, overflow_d;
  logic                triggered_q, triggered_d;
  logic                mode_q, mode_d;
  logic [PCNT_W-1:0]   remaining_q, remaining_d;
  logic                wr_en;
  logic [E-1:0]        wr_entry;
  logic                full;
  logic                will_fill;
  logic                trig_hit;

  logic [E-1:0]        mem_q [DEPTH];

  assign wr_entry  = {stamp_q, pc_in, hold_in, flush_in, fw1_in, fw2_in, regs_in};
  assign full      = (count_q == CW'(DEPTH));
  // In fill-stop mode the write that lands on the last free slot ends the capture.
  assign will_fill = !mode_q && (count_q == CW'(DEPTH - 1));
  assign trig_hit  = trig_en && (pc_in == trig_pc);

  // State and bookkeeping registers; reset discards any capture in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stamp_q     <= '0;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
      mode_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stamp_q     <= stamp_d;
      overflow_q  <= overflow_d;
      triggered_q <= triggered_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
    end
  end

  // Trace memory is not reset; only entries counted by count are meaningful.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Next-state: arm/pop while idle or done, capture/trigger/stop while recording.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    stamp_d     = stamp_q;
    overflow_d  = overflow_q;
    triggered_d = triggered_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    wr_en       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          count_d     = '0;
          stamp_d     = '0;
          overflow_d  = 1'b0;
          triggered_d = 1'b0;
          mode_d      = mode;
          state_d     = S_CAPTURE;
        end else if (rd_ready && (count_q != '0)) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          count_d  = count_q - CW'(1);
        end
      end

      S_CAPTURE, S_POST: begin
        if (stop) begin
          state_d = S_DONE;
        end else begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          stamp_d  = stamp_q + STAMP_W'(1);
          // A full ring drops its oldest entry; count stays at DEPTH.
          if (full) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end

          if (state_q == S_CAPTURE) begin
            if (trig_hit) begin
              triggered_d = 1'b1;
              remaining_d = post_count;
              state_d     = (post_count == '0) ? S_DONE : S_POST;
            end
          end else begin
            remaining_d = remaining_q - PCNT_W'(1);
            if (remaining_q == PCNT_W'(1)) begin
              state_d = S_DONE;
            end
          end

          if (will_fill) begin
            state_d = S_DONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: the drain port is only live outside of a capture.
  always_comb begin
    rd_valid  = ((state_q == S_IDLE) || (state_q == S_DONE)) && (count_q != '0);
    rd_data   = mem_q[rd_ptr_q];
    state     = state_q;
    count     = count_q;
    overflow  = overflow_q;
    triggered = triggered_q;
  end

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb/tb_pipeline_trace_buffer.sv - directed self-checking bench for pipeline_trace_buffer
module tb_pipeline_trace_buffer;

  localparam int E  = 16 + 32 + 6 + 4 * 32;
  localparam int RB = 4 * 32;

  logic          clock;
  logic          reset_n;
  logic [31:0]   pc_in;
  logic          hold_in;
  logic          flush_in;
  logic [1:0]    fw1_in;
  logic [1:0]    fw2_in;
  logic [127:0]  regs_in;
  logic          arm;
  logic          stop;
  logic          mode;
  logic          trig_en;
  logic [31:0]   trig_pc;
  logic [7:0]    post_count;
  logic          rd_valid;
  logic          rd_ready;
  logic [E-1:0]  rd_data;
  logic [1:0]    state;
  logic [4:0]    count;
  logic          overflow;
  logic          triggered;

  int n_vec;
  int n_err;

  pipeline_trace_buffer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pc_in      (pc_in),
    .hold_in    (hold_in),
    .flush_in   (flush_in),
    .fw1_in     (fw1_in),
    .fw2_in     (fw2_in),
    .regs_in    (regs_in),
    .arm        (arm),
    .stop       (stop),
    .mode       (mode),
    .trig_en    (trig_en),
    .trig_pc    (trig_pc),
    .post_count (post_count),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .state      (state),
    .count      (count),
    .overflow   (overflow),
    .triggered  (triggered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] f_stamp(input logic [E-1:0] d);
    return 64'(d[E-1 -: 16]);
  endfunction

  function automatic logic [63:0] f_pc(input logic [E-1:0] d);
    return 64'(d[E-17 -: 32]);
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    pc_in = '0; hold_in = 1'b0; flush_in = 1'b0; fw1_in = '0; fw2_in = '0;
    regs_in = '0; arm = 1'b0; stop = 1'b0; mode = 1'b0; trig_en = 1'b0;
    trig_pc = '0; post_count = '0; rd_ready = 1'b0;
    #12;
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_trig", 64'(triggered), 64'd0);
    reset_n = 1'b1;
    tick();

    // Fill-stop capture of 16 entries
    arm = 1'b1; mode = 1'b0; trig_en = 1'b0;
    tick();
    arm = 1'b0;
    check("fs_capture", 64'(state), 64'd1);
    check("fs_valid_cap", 64'(rd_valid), 64'd0);
    for (int i = 0; i < 16; i++) begin
      pc_in = 32'(4 * i);
      regs_in = {32'hA000_0000 + 32'(i), 32'd0, 32'd0, 32'(i * 17)};
      tick();
    end
    check("fs_done", 64'(state), 64'd3);
    check("fs_count", 64'(count), 64'd16);
    check("fs_ovf", 64'(overflow), 64'd0);
    check("fs_valid", 64'(rd_valid), 64'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fs_stamp", f_stamp(rd_data), 64'(i));
      check("fs_pc", f_pc(rd_data), 64'(4 * i));
      check("fs_reg0", 64'(rd_data[31:0]), 64'(i * 17));
      check("fs_reg3", 64'(rd_data[127:96]), 64'(32'hA000_0000 + 32'(i)));
      tick();
    end
    rd_ready = 1'b0;
    check("fs_empty_valid", 64'(rd_valid), 64'd0);
    check("fs_empty_count", 64'(count), 64'd0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("fs_pop_empty", 64'(count), 64'd0);

    // Ring mode with trigger at 0x40 and three post-trigger entries
    arm = 1'b1; mode = 1'b1; trig_en = 1'b1; trig_pc = 32'h40; post_count = 8'd3;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pc_in = 32'(4 * i);
      tick();
      if (i == 15) check("ring_cap15", 64'(state), 64'd1);
      if (i == 16) check("ring_post", 64'(state), 64'd2);
    end
    check("ring_done", 64'(state), 64'd3);
    check("ring_count", 64'(count), 64'd16);
    check("ring_ovf", 64'(overflow), 64'd1);
    check("ring_trig", 64'(triggered), 64'd1);
    rd_ready = 1'b1;
    for (int i = 4; i < 20; i++) begin
      check("ring_stamp", f_stamp(rd_data), 64'(i));
      check("ring_pc", f_pc(rd_data), 64'(4 * i));
      tick();
    end
    rd_ready = 1'b0;
    check("ring_empty", 64'(rd_valid), 64'd0);

    // Trigger at stamp 2 with no post window
    arm = 1'b1; mode = 1'b0; trig_en = 1'b1; trig_pc = 32'h8; post_count = 8'd0;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'(4 * i);
      tick();
    end
    check("p0_done", 64'(state), 64'd3);
    check("p0_count", 64'(count), 64'd3);
    check("p0_trig", 64'(triggered), 64'd1);
    rd_ready = 1'b1;
    tick();
    tick();
    rd_ready = 1'b0;
    check("p0_last_pc", f_pc(rd_data), 64'h8);
    check("p0_last_stamp", f_stamp(rd_data), 64'd2);

    // stop coincident with a trigger at stamp 5; also check control fields
    arm = 1'b1; mode = 1'b0; trig_en = 1'b1; trig_pc = 32'h14; post_count = 8'd2;
    tick();
    arm = 1'b0;
    hold_in = 1'b1; flush_in = 1'b0; fw1_in = 2'd2; fw2_in = 2'd1;
    for (int i = 0; i < 5; i++) begin
      pc_in = 32'(4 * i);
      tick();
    end
    pc_in = 32'h14; stop = 1'b1;
    tick();
    stop = 1'b0;
    hold_in = 1'b0; fw1_in = 2'd0; fw2_in = 2'd0;
    check("st_done", 64'(state), 64'd3);
    check("st_count", 64'(count), 64'd5);
    check("st_trig", 64'(triggered), 64'd0);
    check("st_hold", 64'(rd_data[RB+5]), 64'd1);
    check("st_flush", 64'(rd_data[RB+4]), 64'd0);
    check("st_fw1", 64'(rd_data[RB+3 -: 2]), 64'd2);
    check("st_fw2", 64'(rd_data[RB+1 -: 2]), 64'd1);

    // Backpressure holds data; then pop one; then arm beats a pop
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_stamp", f_stamp(rd_data), 64'd0);
      check("bp_count", 64'(count), 64'd5);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("bp_pop_count", 64'(count), 64'd4);
    check("bp_pop_stamp", f_stamp(rd_data), 64'd1);
    mode = 1'b0; trig_en = 1'b1; trig_pc = 32'h8; post_count = 8'd5;
    arm = 1'b1; rd_ready = 1'b1;
    tick();
    arm = 1'b0; rd_ready = 1'b0;
    check("arm_pop_state", 64'(state), 64'd1);
    check("arm_pop_count", 64'(count), 64'd0);
    check("arm_pop_valid", 64'(rd_valid), 64'd0);

    // Asynchronous reset in the middle of the post-trigger window
    for (int i = 0; i < 4; i++) begin
      pc_in = 32'(4 * i);
      tick();
    end
    check("ar_post", 64'(state), 64'd2);
    check("ar_count_pre", 64'(count), 64'd4);
    #2 reset_n = 1'b0;
    #1;
    check("ar_state", 64'(state), 64'd0);
    check("ar_count", 64'(count), 64'd0);
    check("ar_valid", 64'(rd_valid), 64'd0);
    check("ar_trig", 64'(triggered), 64'd0);
    check("ar_ovf", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    tick();

    // Re-arm after reset: two entries then stop
    arm = 1'b1; mode = 1'b0; trig_en = 1'b0;
    tick();
    arm = 1'b0;
    pc_in = 32'h100;
    tick();
    pc_in = 32'h104;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("re_state", 64'(state), 64'd3);
    check("re_count", 64'(count), 64'd2);
    check("re_stamp", f_stamp(rd_data), 64'd0);
    check("re_pc", f_pc(rd_data), 64'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_trace_buffer.md
# pipeline_trace_buffer

On-chip trace capture for the five-stage pipeline: every clock it records PC, IF/ID hold and flush, forwarding selects Fw1/Fw2, a stamp and NUM_REGS watched register values into a DEPTH-entry buffer. It has fill-stop and ring modes, PC-match triggering with a programmable post-trigger window, and a ready/valid drain port. It sits beside `Pipeline`, taps its internal signals and replaces per-half-cycle textual dumps with hardware capture.

## Interface
- ADDR_W, 32, PC width
- REG_W, 32, watched register width
- NUM_REGS, 4, watched register channels
- DEPTH, 16, entries; power of two, ≥2
- STAMP_W, 16, cycle stamp width
- PCNT_W, 8, post-trigger count width
- Entry width E = STAMP_W + ADDR_W + 6 + NUM_REGS*REG_W. Packing MSB→LSB: stamp, pc, hold, flush, fw1, fw2, regs (channel 0 in the LSBs).
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- pc_in  in  ADDR_W  PC of the core
- hold_in  in  1  IF/ID hold
- flush_in  in  1  IF/ID flush
- fw1_in, fw2_in  in  2 each  forwarding selects
- regs_in  in  NUM_REGS*REG_W  watched register values
- arm  in  1  start a capture (level sampled each edge)
- stop  in  1  end a capture
- mode  in  1  0 = fill-stop, 1 = ring; sampled at arm
- trig_en  in  1  enable PC-match trigger
- trig_pc  in  ADDR_W  trigger PC
- post_count  in  PCNT_W  entries captured after the trigger entry; sampled at trigger
- rd_valid  out  1  entry available
- rd_ready  in  1  consumer accepts entry
- rd_data  out  E  oldest stored entry
- state  out  2  IDLE=0, CAPTURE=1, POST=2, DONE=3
- count  out  $clog2(DEPTH)+1  entries stored
- overflow  out  1  sticky: an entry was overwritten
- triggered  out  1  sticky: trigger fired

## Operation
- Storage: circular memory with wr_ptr, rd_ptr and count. Pointers wrap modulo DEPTH.
- IDLE / DONE:
  - arm=1: clear pointers, count, stamp, overflow and triggered; latch mode; go to CAPTURE. arm wins over a same-cycle pop.
  - rd_valid = (count≠0). rd_data = mem[rd_ptr].
  - rd_valid & rd_ready: rd_ptr+1, count−1.
- CAPTURE / POST:
  - rd_valid=0; arm is ignored.
  - Each edge writes {stamp, inputs} at wr_ptr, then wr_ptr+1 and stamp+1. The stamp wraps at 2^STAMP_W.
  - Ring mode, count=DEPTH: the write overwrites the oldest entry, rd_ptr+1, count is unchanged, overflow is set.
  - Fill-stop mode: the write that makes count=DEPTH also moves to DONE.
- Trigger (CAPTURE only): trig_en & pc_in==trig_pc.
  - The trigger-cycle entry is written and triggered is set.
  - post_count=0: go to DONE. Otherwise go to POST with remaining=post_count.
- POST: each write decrements remaining; the write with remaining=1 moves to DONE. In fill-stop mode, full also moves to DONE, whichever comes first.
- stop=1 in CAPTURE/POST: go to DONE; that cycle is not written. stop has priority over a trigger and over a write.
- stop in IDLE/DONE: ignored.

## Timing
- Reset values (asynchronous): state=IDLE, count=0, pointers=0, stamp=0, overflow=0, triggered=0, rd_valid=0.
  - rd_data is don't-care while rd_valid=0.
  - Memory contents are not reset.
  - Reset mid-capture discards all entries immediately.
- arm sampled at edge N: state=CAPTURE after N. The first entry (stamp 0) captures the inputs present at edge N+1.
- Entries are visible in count after their write edge. rd_valid rises the cycle after entering DONE with count>0.
- rd_data is combinational from mem[rd_ptr]. With rd_ready=0 it stays stable while rd_valid=1.
- Pop throughput: one entry per cycle.
- count never exceeds DEPTH and never underflows; a pop with count=0 is ignored.

## Test plan
- Fill-stop: arm, mode=0, trig_en=0, pc_in = 4×cycle → DONE after 16 writes, count=16, overflow=0. Popping with rd_ready=1 returns stamps 0..15 and pc 0x00..0x3C, then rd_valid=0.
- Ring + trigger: mode=1, trig_pc=0x40, post_count=3, pc_in from 0 step 4 → trigger at stamp 16, DONE after stamp 19. count=16, overflow=1, triggered=1; pops give stamps 4..19.
- Trigger with post_count=0 at pc_in=0x8 (stamp 2) → DONE, count=3, last entry pc=0x8.
- stop and trigger in the same cycle at stamp 5 → DONE, count=5, triggered=0. hold/flush/fw1=2/fw2=1 fields match the driven values.
- Backpressure: in DONE, hold rd_ready=0 for 3 cycles → rd_data and count unchanged. Assert arm together with rd_ready → buffer cleared, state=CAPTURE, no pop.
- Assert reset_n=0 mid-POST between edges → immediately IDLE, count=0, rd_valid=0, flags 0. Re-arm captures stamp 0 correctly.
